// File: rtl/counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : counter_pkg                                                |
// | Description : Shared definitions for the 8Queen index counters: mode     |
// |               encodings for sat_mode, board geometry constants and the   |
// |               clamp-to-range helper used by load and saturate logic.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package counter_pkg;

  // sat_mode encodings
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // 8Queen board geometry: index counters use N=IDX_W, MAX=BOARD_N-1
  localparam int BOARD_N = 8;
  localparam int IDX_W   = 3;

  // Clamp an unsigned quantity into 0..max_val. Operands are carried at
  // 32 bits so the helper serves any counter width up to 31.
  function automatic logic [31:0] clamp_to_range(input logic [31:0] val,
                                                 input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : updown_mod_counter                                         |
// | Description : Up/down counter over 0..MAX (modulus MAX+1) with runtime   |
// |               wrap/saturate mode, synchronous clear, clamped parallel    |
// |               load, zero/terminal flags and registered carry/borrow      |
// |               pulses for cascading.                                      |
// | Revision    : 1.0  initial release                                       |
// |                                                                          |
// | Build option: UPDOWN_MOD_COUNTER_STEP_EN adds input step[N-1:0]; each    |
// |               count moves by step modulo MAX+1. Undefined: step is 1.    |
// |                                                                          |
// | Ports:                                                                   |
// |   clk        in   1  rising-edge clock                                   |
// |   reset      in   1  asynchronous active-low reset                       |
// |   clear      in   1  synchronous clear to RESET_VAL (highest priority)   |
// |   load       in   1  synchronous load of data (clamped to MAX)           |
// |   data       in   N  load value                                          |
// |   count_up   in   1  increment request                                   |
// |   count_down in   1  decrement request                                   |
// |   sat_mode   in   1  1 = saturate at bounds, 0 = wrap modulo MAX+1       |
// |   step       in   N  count stride (only with UPDOWN_MOD_COUNTER_STEP_EN) |
// |   value      out  N  current count (registered)                          |
// |   zero       out  1  value == 0                                          |
// |   at_max     out  1  value == MAX                                        |
// |   msb        out  1  value[N-1]                                          |
// |   carry      out  1  one-cycle pulse: up-count wrapped past MAX          |
// |   borrow     out  1  one-cycle pulse: down-count wrapped below 0         |
// +--------------------------------------------------------------------------+
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX       = 2**N - 1,
  parameter int RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] data,
  input  logic         count_up,
  input  logic         count_down,
  input  logic         sat_mode,
`ifdef UPDOWN_MOD_COUNTER_STEP_EN
  input  logic [N-1:0] step,
`endif
  output logic [N-1:0] value,
  output logic         zero,
  output logic         at_max,
  output logic         msb,
  output logic         carry,
  output logic         borrow
);

  // All arithmetic is done one bit wider than the counter so that a sum
  // such as MAX+step never aliases back into range when MAX < 2**N-1.
  localparam logic [N:0]   MAX_X   = (N+1)'(MAX);
  localparam logic [N:0]   MOD_X   = (N+1)'(MAX + 1);
  localparam logic [N-1:0] MAX_V   = N'(MAX);
  localparam logic [N-1:0] RESET_V = N'(RESET_VAL);

  logic [N:0]   step_x;
  logic [N:0]   value_x;
  logic [N:0]   sum_x;
  logic [N:0]   wrap_dn_x;
  logic [N-1:0] value_nxt;
  logic         carry_nxt;
  logic         borrow_nxt;
  logic         do_up;
  logic         do_down;

`ifdef UPDOWN_MOD_COUNTER_STEP_EN
  // A stride larger than the modulus is equivalent to its residue; reducing
  // it first keeps every sum below 2*(MAX+1) so a single wrap suffices.
  assign step_x = {1'b0, step} % MOD_X;
`else
  assign step_x = (N+1)'(1);
`endif

  assign value_x = {1'b0, value};
  assign sum_x   = value_x + step_x;
  // Down-count that crosses zero: value - step + (MAX+1). Only used when
  // value < step, so the result is always within 0..MAX.
  assign wrap_dn_x = (MOD_X - step_x) + value_x;

  // Simultaneous up and down requests cancel out.
  assign do_up   = count_up & ~count_down;
  assign do_down = count_down & ~count_up;

  always_comb begin
    value_nxt  = value;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;

    if (clear) begin
      value_nxt = RESET_V;
    end else if (load) begin
      value_nxt = N'(clamp_to_range(32'(data), 32'(MAX)));
    end else if (do_up) begin
      if (sum_x > MAX_X) begin
        if (sat_mode == MODE_SAT) begin
          value_nxt = N'(clamp_to_range(32'(sum_x), 32'(MAX)));
        end else begin
          value_nxt = N'(sum_x - MOD_X);
          carry_nxt = 1'b1;
        end
      end else begin
        value_nxt = N'(sum_x);
      end
    end else if (do_down) begin
      if (value_x < step_x) begin
        if (sat_mode == MODE_SAT) begin
          value_nxt = '0;
        end else begin
          value_nxt  = N'(wrap_dn_x);
          borrow_nxt = 1'b1;
        end
      end else begin
        value_nxt = N'(value_x - step_x);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value  <= RESET_V;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      value  <= value_nxt;
      carry  <= carry_nxt;
      borrow <= borrow_nxt;
    end
  end

  // Flags decode straight from the register so they are valid in the same
  // cycle as value, including while reset is held.
  assign zero   = (value == '0);
  assign at_max = (value == MAX_V);
  assign msb    = value[N-1];

endmodule : updown_mod_counter
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_updown_mod_counter                                      |
// | Description : Scoreboard bench for updown_mod_counter. Two instances:    |
// |               dut9 (N=4, MAX=9, RESET_VAL=0) and dut7 (N=4, MAX=7,       |
// |               RESET_VAL=3) share the stimulus; each expectation names    |
// |               the instance it applies to.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] data = 4'd0;
  logic       count_up = 1'b0;
  logic       count_down = 1'b0;
  logic       sat_mode = 1'b0;
`ifdef UPDOWN_MOD_COUNTER_STEP_EN
  logic [3:0] step = 4'd1;
`endif

  logic [3:0] value9, value7;
  logic       zero9, at_max9, msb9, carry9, borrow9;
  logic       zero7, at_max7, msb7, carry7, borrow7;

  updown_mod_counter #(.N(4), .MAX(9), .RESET_VAL(0)) dut9 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .data(data),
    .count_up(count_up), .count_down(count_down), .sat_mode(sat_mode),
`ifdef UPDOWN_MOD_COUNTER_STEP_EN
    .step(step),
`endif
    .value(value9), .zero(zero9), .at_max(at_max9), .msb(msb9),
    .carry(carry9), .borrow(borrow9)
  );

  updown_mod_counter #(.N(4), .MAX(7), .RESET_VAL(3)) dut7 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .data(data),
    .count_up(count_up), .count_down(count_down), .sat_mode(sat_mode),
`ifdef UPDOWN_MOD_COUNTER_STEP_EN
    .step(step),
`endif
    .value(value7), .zero(zero7), .at_max(at_max7), .msb(msb7),
    .carry(carry7), .borrow(borrow7)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         which;   // 0 = dut9, 1 = dut7
    logic [3:0] val;
    logic       c;
    logic       b;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input bit which, input logic [3:0] v,
                               input logic c, input logic b,
                               input string nm, input int tgt);
    exp_t e;
    e.cyc = tgt; e.which = which; e.val = v; e.c = c; e.b = b; e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: on each falling edge, retire every expectation due by now.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [8:0] act;
    logic [8:0] req;
    int         mx;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      mx  = e.which ? 7 : 9;
      act = e.which ? {value7, zero7, at_max7, msb7, carry7, borrow7}
                    : {value9, zero9, at_max9, msb9, carry9, borrow9};
      req = {e.val, (e.val == 4'd0), (e.val == 4'(mx)), e.val[3], e.c, e.b};
      checks++;
      if (act !== req) begin
        fails++;
        $display("FAIL %s: got value=%0d zero=%b at_max=%b msb=%b carry=%b borrow=%b, expected value=%0d zero=%b at_max=%b msb=%b carry=%b borrow=%b",
                 e.name, act[8:5], act[4], act[3], act[2], act[1], act[0],
                 req[8:5], req[4], req[3], req[2], req[1], req[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Apply one cycle of stimulus and queue the expected post-edge state.
  task automatic stim(input bit which, input logic clr, input logic ld,
                      input logic [3:0] d, input logic up, input logic dn,
                      input logic sat, input logic [3:0] ev, input logic ec,
                      input logic eb, input string nm);
    clear = clr; load = ld; data = d; count_up = up; count_down = dn;
    sat_mode = sat;
    push(which, ev, ec, eb, nm, cyc + 1);
    tick();
  endtask

  // Pull reset low between clock edges; the reset state must appear at the
  // following falling edge with no rising edge in between.
  task automatic rst_pulse(input logic up, input string nm);
    clear = 1'b0; load = 1'b0; count_up = up; count_down = 1'b0;
    sat_mode = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    push(1'b0, 4'd0, 1'b0, 1'b0, {nm, "_9"}, cyc);
    push(1'b1, 4'd3, 1'b0, 1'b0, {nm, "_7"}, cyc);
    @(negedge clk);
    #2 reset = 1'b1;
    count_up = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    // Reset state of both instances
    push(1'b0, 4'd0, 1'b0, 1'b0, "reset_9", 1);
    push(1'b1, 4'd3, 1'b0, 1'b0, "reset_7", 1);
    @(negedge clk);
    #1 reset = 1'b1;

    //    which clr ld data up dn sat  -> val c b
    stim(0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 0, 0, "hold_after_rst");

    // Reset mid-count
    stim(0, 0, 1, 4'd3,  0, 0, 0, 4'd3, 0, 0, "load3");
    stim(0, 0, 0, 4'd0,  1, 0, 0, 4'd4, 0, 0, "up4");
    stim(0, 0, 0, 4'd0,  1, 0, 0, 4'd5, 0, 0, "up5");
    rst_pulse(1'b0, "async_rst_mid");
    stim(0, 0, 0, 4'd0,  1, 0, 0, 4'd1, 0, 0, "resume_after_rst");

    // Reset must also kill a carry pulse that was just registered
    stim(0, 0, 1, 4'd9,  0, 0, 0, 4'd9, 0, 0, "load9");
    rst_pulse(1'b1, "async_rst_carry");

    // Wrap up, MAX=7
    stim(1, 0, 1, 4'd6,  0, 0, 0, 4'd6, 0, 0, "wrap_load6");
    stim(1, 0, 0, 4'd0,  1, 0, 0, 4'd7, 0, 0, "wrap_up_7");
    stim(1, 0, 0, 4'd0,  1, 0, 0, 4'd0, 1, 0, "wrap_up_0");
    stim(1, 0, 0, 4'd0,  0, 0, 0, 4'd0, 0, 0, "carry_one_cycle");

    // Saturate at both ends, MAX=9
    stim(0, 0, 1, 4'd9,  0, 0, 1, 4'd9, 0, 0, "sat_load9");
    for (int i = 0; i < 3; i++)
      stim(0, 0, 0, 4'd0, 1, 0, 1, 4'd9, 0, 0, "sat_up_hold");
    stim(0, 0, 1, 4'd0,  0, 0, 1, 4'd0, 0, 0, "sat_load0");
    stim(0, 0, 0, 4'd0,  0, 1, 1, 4'd0, 0, 0, "sat_dn_hold");

    // Load clamp and wrap down
    stim(0, 0, 1, 4'd12, 0, 0, 0, 4'd9, 0, 0, "load_clamp_9");
    stim(1, 0, 1, 4'd15, 0, 0, 0, 4'd7, 0, 0, "load_clamp_7");
    stim(0, 0, 1, 4'd0,  0, 0, 0, 4'd0, 0, 0, "load0");
    stim(0, 0, 0, 4'd0,  0, 1, 0, 4'd9, 0, 1, "wrap_dn_9");
    stim(0, 0, 0, 4'd0,  0, 0, 0, 4'd9, 0, 0, "borrow_one_cycle");
    stim(0, 0, 0, 4'd0,  0, 1, 0, 4'd8, 0, 0, "dn_8_msb");

    // Priority and simultaneous requests, MAX=7, RESET_VAL=3
    stim(1, 0, 1, 4'd2,  0, 0, 0, 4'd2, 0, 0, "prio_load2");
    stim(1, 1, 1, 4'd5,  1, 0, 0, 4'd3, 0, 0, "clear_over_load");
    stim(1, 0, 1, 4'd5,  1, 0, 0, 4'd5, 0, 0, "load_over_up");
    stim(1, 0, 1, 4'd4,  0, 0, 0, 4'd4, 0, 0, "prio_load4");
    stim(1, 0, 0, 4'd0,  1, 1, 0, 4'd4, 0, 0, "up_dn_hold");
    stim(1, 0, 0, 4'd0,  0, 1, 0, 4'd3, 0, 0, "dn_3");

    // sat_mode changing cycle to cycle
    stim(1, 0, 1, 4'd7,  0, 0, 0, 4'd7, 0, 0, "mode_load7");
    stim(1, 0, 0, 4'd0,  1, 0, 1, 4'd7, 0, 0, "mode_sat_hold");
    stim(1, 0, 0, 4'd0,  1, 0, 0, 4'd0, 1, 0, "mode_wrap_up");
    stim(1, 0, 0, 4'd0,  0, 1, 0, 4'd7, 0, 1, "mode_wrap_dn");
    stim(1, 1, 0, 4'd0,  1, 0, 0, 4'd3, 0, 0, "clear_over_wrap");

`ifdef UPDOWN_MOD_COUNTER_STEP_EN
    step = 4'd3;
    stim(1, 0, 1, 4'd6,  0, 0, 0, 4'd6, 0, 0, "step_load6");
    stim(1, 0, 0, 4'd0,  1, 0, 0, 4'd1, 1, 0, "step3_wrap_up");
    stim(1, 0, 1, 4'd6,  0, 0, 1, 4'd6, 0, 0, "step_load6_sat");
    stim(1, 0, 0, 4'd0,  1, 0, 1, 4'd7, 0, 0, "step3_sat_up");
    step = 4'd0;
    stim(1, 0, 0, 4'd0,  1, 0, 0, 4'd7, 0, 0, "step0_hold");
    step = 4'd9;
    stim(1, 0, 1, 4'd2,  0, 0, 0, 4'd2, 0, 0, "step_load2");
    stim(1, 0, 0, 4'd0,  1, 0, 0, 4'd3, 0, 0, "step9_mod_up");
    step = 4'd3;
    stim(1, 0, 1, 4'd1,  0, 0, 0, 4'd1, 0, 0, "step_load1");
    stim(1, 0, 0, 4'd0,  0, 1, 0, 4'd6, 0, 1, "step3_wrap_dn");
    step = 4'd1;
`endif

    clear = 1'b0; load = 1'b0; count_up = 1'b0; count_down = 1'b0;
    tick();
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_updown_mod_counter
`default_nettype wire
